// File: rtl/bch_encoder_par_if.sv
// bch_encoder_par_if: bit-serial stream bundle between bit source, encoder and channel stage
//   in_valid/in_ready/in_data        : message bit stream into the encoder
//   out_valid/out_ready/out_data     : codeword bit stream out of the encoder
//   out_sof/out_last                 : first/last bit markers of each codeword
//   modport master : encoder side; modport slave : surrounding source/sink side
interface bch_encoder_par_if;
  logic in_valid;
  logic in_ready;
  logic in_data;
  logic out_valid;
  logic out_ready;
  logic out_data;
  logic out_sof;
  logic out_last;
  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_last
  );
  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_last
  );
endinterface

// File: rtl/bch_encoder_par.sv
// bch_encoder_par: serial systematic BCH/cyclic encoder, message bits forwarded then N-K parity bits appended
//   clk    : clock, rising edge
//   rst    : synchronous active-low reset
//   bypass : present only when BCH_ENC_BYPASS_EN is defined; latched at frame start, 1 = message-only frame
//   bus    : bch_encoder_par_if.master, valid/ready input bit stream and output codeword stream with sof/last
module bch_encoder_par #(
  parameter int N = 63,
  parameter int K = 51,
  parameter logic [N-K:0] GEN_POLY = 13'h1539
) (
  input logic clk,
  input logic rst,
`ifdef BCH_ENC_BYPASS_EN
  input logic bypass,
`endif
  bch_encoder_par_if.master bus
);
  localparam int R = N - K;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] KM1 = CW'(K - 1);
  localparam logic [CW-1:0] NM1 = CW'(N - 1);
  localparam logic [R-1:0] POLY = GEN_POLY[R-1:0];
  if (K >= N || !GEN_POLY[R] || !GEN_POLY[0]) begin : g_bad_params
    $error("bch_encoder_par: need K < N and GEN_POLY with x^(N-K) and x^0 terms set");
  end
  typedef enum logic {DATA, PAR} state_t;
  state_t state_q, state_d;
  logic [R-1:0] lfsr_q, lfsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d, data_q, data_d, sof_q, sof_d, last_q, last_d;
  logic slot_free, accept, fb, byp;
`ifdef BCH_ENC_BYPASS_EN
  logic byp_q, byp_d;
  // the first bit of a frame sees the live bypass input, later bits the latched copy
  assign byp = (cnt_q == '0) ? bypass : byp_q;
  assign byp_d = (accept && cnt_q == '0) ? bypass : byp_q;
  always_ff @(posedge clk)
    byp_q <= !rst ? 1'b0 : byp_d;
`else
  assign byp = 1'b0;
`endif
  always_comb begin
    slot_free = !valid_q || bus.out_ready;
    bus.in_ready = rst && state_q == DATA && slot_free;
    accept = bus.in_valid && bus.in_ready;
    fb = bus.in_data ^ lfsr_q[R-1];
    state_d = state_q;
    lfsr_d = lfsr_q;
    cnt_d = cnt_q;
    valid_d = slot_free ? 1'b0 : valid_q;
    data_d = data_q;
    sof_d = sof_q;
    last_d = last_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d = bus.in_data;
      sof_d = cnt_q == '0;
      last_d = byp && cnt_q == KM1;
      lfsr_d = (lfsr_q << 1) ^ (fb ? POLY : '0);
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == KM1) begin
        state_d = byp ? DATA : PAR;
        cnt_d = byp ? '0 : cnt_d;
        lfsr_d = byp ? '0 : lfsr_d;
      end
    end else if (state_q == PAR && slot_free) begin
      valid_d = 1'b1;
      data_d = lfsr_q[R-1];
      sof_d = 1'b0;
      last_d = cnt_q == NM1;
      lfsr_d = lfsr_q << 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == NM1) begin
        state_d = DATA;
        cnt_d = '0;
        lfsr_d = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DATA;
      lfsr_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      data_q <= 1'b0;
      sof_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      data_q <= data_d;
      sof_q <= sof_d;
      last_q <= last_d;
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.out_data = data_q;
  assign bus.out_sof = sof_q;
  assign bus.out_last = last_q;
endmodule

// File: tb/tb_bch_encoder_par.sv
// tb_bch_encoder_par: directed self-checking bench for bch_encoder_par
module tb_bch_encoder_par;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  bch_encoder_par_if b0();
  bch_encoder_par_if b7();
  bch_encoder_par_if b11();
`ifdef BCH_ENC_BYPASS_EN
  logic bypass = 1'b0;
`endif
  bch_encoder_par dut (
    .clk(clk), .rst(rst),
`ifdef BCH_ENC_BYPASS_EN
    .bypass(bypass),
`endif
    .bus(b0)
  );
  bch_encoder_par #(.N(15), .K(7), .GEN_POLY(9'h1D1)) dut7 (
    .clk(clk), .rst(rst),
`ifdef BCH_ENC_BYPASS_EN
    .bypass(1'b0),
`endif
    .bus(b7)
  );
  bch_encoder_par #(.N(15), .K(11), .GEN_POLY(5'h13)) dut11 (
    .clk(clk), .rst(rst),
`ifdef BCH_ENC_BYPASS_EN
    .bypass(1'b0),
`endif
    .bus(b11)
  );
  always #5 clk = ~clk;

  logic [50:0] msgs [2];
  bit qd[$], qs[$], ql[$];
  int irlow, first_acc, last_cyc, stall_viol, nout;

  // packs len captured bits starting at off, first captured bit in the MSB; sel 0 data, 1 sof, 2 last
  function automatic logic [62:0] pk(input int sel, input int off, input int len);
    logic [62:0] r = '0;
    for (int i = 0; i < len; i++)
      if (off + i < qd.size())
        r[len-1-i] = sel == 0 ? qd[off+i] : sel == 1 ? qs[off+i] : ql[off+i];
    return r;
  endfunction

  // feeds nf frames from msgs into the default encoder and captures total output bits
  task automatic drive(input int nf, input bit stall, input bit byp0, input int total);
    int mi = 0;
    int fi = 0;
    int cyc = 0;
    logic [3:0] prev = '0;
    bit hold = 0;
    qd.delete(); qs.delete(); ql.delete();
    irlow = 0; stall_viol = 0; nout = 0; first_acc = -1; last_cyc = -1;
    while (nout < total && cyc < 4 * total + 50) begin
      @(negedge clk);
      if (hold && {b0.out_valid, b0.out_data, b0.out_sof, b0.out_last} !== prev) stall_viol++;
      b0.out_ready = stall ? (cyc % 3 != 1 && cyc % 7 != 3) : 1'b1;
      b0.in_valid = fi < nf;
      b0.in_data = fi < nf ? msgs[fi][50-mi] : 1'b0;
`ifdef BCH_ENC_BYPASS_EN
      bypass = (fi == 0 && byp0) ? (mi % 2 == 0) : 1'b0;
`endif
      #1;
      if (!b0.in_ready) irlow++;
      prev = {b0.out_valid, b0.out_data, b0.out_sof, b0.out_last};
      hold = b0.out_valid && !b0.out_ready;
      if (b0.out_valid && b0.out_ready) begin
        qd.push_back(b0.out_data); qs.push_back(b0.out_sof); ql.push_back(b0.out_last);
        nout++;
        if (b0.out_last) last_cyc = cyc;
      end
      if (b0.in_valid && b0.in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        mi++;
        if (mi == 51) begin mi = 0; fi++; end
      end
      cyc++;
    end
    @(negedge clk);
    b0.in_valid = 1'b0;
    b0.out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    b0.in_valid = 1'b1; b0.in_data = 1'b1; b0.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", b0.out_valid); end
    checks++; if (b0.out_data !== 1'b0) begin errors++; $display("FAIL rst_data got %b exp 0", b0.out_data); end
    checks++; if ({b0.out_sof, b0.out_last} !== 2'b00) begin errors++; $display("FAIL rst_marks got %b exp 00", {b0.out_sof, b0.out_last}); end
    checks++; if (b0.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", b0.in_ready); end
    checks++; if ({b7.out_valid, b11.out_valid} !== 2'b00) begin errors++; $display("FAIL rst_small_valid got %b exp 00", {b7.out_valid, b11.out_valid}); end
    rst = 1'b1; b0.in_valid = 1'b0;
    #1;
    checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", b0.in_ready); end
  endtask

  task automatic test_zero_frame;
    msgs[0] = '0;
    drive(1, 0, 0, 63);
    checks++; if (nout !== 63) begin errors++; $display("FAIL zero_count got %0d exp 63", nout); end
    checks++; if (pk(0, 0, 63) !== 63'h0) begin errors++; $display("FAIL zero_cw got %h exp 0", pk(0, 0, 63)); end
    checks++; if (pk(1, 0, 63) !== {1'b1, 62'b0}) begin errors++; $display("FAIL zero_sof got %h exp %h", pk(1, 0, 63), {1'b1, 62'b0}); end
    checks++; if (pk(2, 0, 63) !== 63'h1) begin errors++; $display("FAIL zero_last got %h exp 1", pk(2, 0, 63)); end
    checks++; if (irlow !== 12) begin errors++; $display("FAIL zero_inready_low got %0d exp 12", irlow); end
  endtask

  task automatic test_single_one;
    msgs[0] = 51'h1;
    drive(1, 0, 0, 63);
    checks++; if (pk(0, 0, 63) !== {51'h1, 12'h539}) begin errors++; $display("FAIL one_cw got %h exp %h", pk(0, 0, 63), {51'h1, 12'h539}); end
    checks++; if (last_cyc - first_acc !== 63) begin errors++; $display("FAIL one_latency got %0d exp 63", last_cyc - first_acc); end
  endtask

  task automatic test_back_to_back;
    msgs[0] = 51'h2; msgs[1] = 51'h3;
    drive(2, 0, 0, 126);
    checks++; if (pk(0, 0, 63) !== {51'h2, 12'hA72}) begin errors++; $display("FAIL b2b_cw0 got %h exp %h", pk(0, 0, 63), {51'h2, 12'hA72}); end
    checks++; if (pk(0, 63, 63) !== {51'h3, 12'hF4B}) begin errors++; $display("FAIL b2b_cw1 got %h exp %h", pk(0, 63, 63), {51'h3, 12'hF4B}); end
    checks++; if (pk(1, 63, 63) !== {1'b1, 62'b0}) begin errors++; $display("FAIL b2b_sof1 got %h exp %h", pk(1, 63, 63), {1'b1, 62'b0}); end
    checks++; if (pk(2, 0, 63) !== 63'h1) begin errors++; $display("FAIL b2b_last0 got %h exp 1", pk(2, 0, 63)); end
    checks++; if (irlow !== 24) begin errors++; $display("FAIL b2b_inready_low got %0d exp 24", irlow); end
  endtask

  task automatic test_stall;
    msgs[0] = 51'h4; msgs[1] = 51'h7;
    drive(2, 1, 0, 126);
    checks++; if (nout !== 126) begin errors++; $display("FAIL stall_count got %0d exp 126", nout); end
    checks++; if (pk(0, 0, 63) !== {51'h4, 12'h1DD}) begin errors++; $display("FAIL stall_cw0 got %h exp %h", pk(0, 0, 63), {51'h4, 12'h1DD}); end
    checks++; if (pk(0, 63, 63) !== {51'h7, 12'hE96}) begin errors++; $display("FAIL stall_cw1 got %h exp %h", pk(0, 63, 63), {51'h7, 12'hE96}); end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL stall_stable got %0d changes exp 0", stall_viol); end
    checks++; if ({pk(1, 63, 63), pk(2, 63, 63)} !== {1'b1, 62'b0, 63'h1}) begin errors++; $display("FAIL stall_marks1 got %h exp %h", {pk(1, 63, 63), pk(2, 63, 63)}, {1'b1, 62'b0, 63'h1}); end
  endtask

  task automatic test_reset_mid_frame;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      b0.in_valid = 1'b1; b0.in_data = i[0]; b0.out_ready = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", b0.out_valid); end
    checks++; if (b0.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", b0.in_ready); end
    rst = 1'b1; b0.in_valid = 1'b0;
    msgs[0] = 51'h1;
    drive(1, 0, 0, 63);
    checks++; if (pk(0, 0, 63) !== {51'h1, 12'h539}) begin errors++; $display("FAIL mid_cw got %h exp %h", pk(0, 0, 63), {51'h1, 12'h539}); end
    checks++; if ({pk(1, 0, 63), pk(2, 0, 63)} !== {1'b1, 62'b0, 63'h1}) begin errors++; $display("FAIL mid_marks got %h exp %h", {pk(1, 0, 63), pk(2, 0, 63)}, {1'b1, 62'b0, 63'h1}); end
  endtask

  task automatic test_short_codes;
    logic [14:0] got = '0;
    logic [14:0] sof = '0;
    logic [14:0] lst = '0;
    int n = 0;
    int mi = 0;
    for (int c = 0; c < 60 && n < 15; c++) begin
      @(negedge clk);
      b7.in_valid = mi < 7; b7.in_data = mi == 6; b7.out_ready = 1'b1;
      #1;
      if (b7.out_valid) begin got[14-n] = b7.out_data; sof[14-n] = b7.out_sof; lst[14-n] = b7.out_last; n++; end
      if (b7.in_valid && b7.in_ready) mi++;
    end
    @(negedge clk); b7.in_valid = 1'b0;
    checks++; if (got !== {7'b0000001, 8'hD1}) begin errors++; $display("FAIL n15k7_cw got %h exp %h", got, {7'b0000001, 8'hD1}); end
    checks++; if ({sof, lst} !== {15'h4000, 15'h0001}) begin errors++; $display("FAIL n15k7_marks got %h exp %h", {sof, lst}, {15'h4000, 15'h0001}); end
    got = '0; n = 0; mi = 0;
    for (int c = 0; c < 60 && n < 15; c++) begin
      @(negedge clk);
      b11.in_valid = mi < 11; b11.in_data = mi == 10; b11.out_ready = 1'b1;
      #1;
      if (b11.out_valid) begin got[14-n] = b11.out_data; n++; end
      if (b11.in_valid && b11.in_ready) mi++;
    end
    @(negedge clk); b11.in_valid = 1'b0;
    checks++; if (got !== {11'b1, 4'h3}) begin errors++; $display("FAIL n15k11_cw got %h exp %h", got, {11'b1, 4'h3}); end
  endtask

`ifdef BCH_ENC_BYPASS_EN
  task automatic test_bypass;
    msgs[0] = 51'h1; msgs[1] = 51'h1;
    drive(2, 0, 1, 114);
    checks++; if (pk(0, 0, 51) !== 63'h1) begin errors++; $display("FAIL byp_msg got %h exp 1", pk(0, 0, 51)); end
    checks++; if (pk(2, 0, 51) !== 63'h1) begin errors++; $display("FAIL byp_last got %h exp 1", pk(2, 0, 51)); end
    checks++; if (pk(1, 51, 63) !== {1'b1, 62'b0}) begin errors++; $display("FAIL byp_next_sof got %h exp %h", pk(1, 51, 63), {1'b1, 62'b0}); end
    checks++; if (pk(0, 51, 63) !== {51'h1, 12'h539}) begin errors++; $display("FAIL byp_next_cw got %h exp %h", pk(0, 51, 63), {51'h1, 12'h539}); end
    checks++; if (pk(2, 51, 63) !== 63'h1) begin errors++; $display("FAIL byp_next_last got %h exp 1", pk(2, 51, 63)); end
  endtask
`endif

  initial begin
    b0.in_valid = 1'b0; b0.in_data = 1'b0; b0.out_ready = 1'b1;
    b7.in_valid = 1'b0; b7.in_data = 1'b0; b7.out_ready = 1'b1;
    b11.in_valid = 1'b0; b11.in_data = 1'b0; b11.out_ready = 1'b1;
    test_reset;
    test_zero_frame;
    test_single_one;
    test_back_to_back;
    test_stall;
    test_reset_mid_frame;
    test_short_codes;
`ifdef BCH_ENC_BYPASS_EN
    test_bypass;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog bench did not finish within time limit");
    $fatal(1);
  end
endmodule
